ps2_key_queue: RTL and testbench

PS2_KEY_QUEUE -- requirements
Module: ps2_key_queue

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_frame_rx.sv | 105 ++++++++++
 rtl/ps2_key_queue.sv | 123 ++++++++++++
 tb/tb_ps2_key_queue.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key-event queue: frame FSM states,
// prefix byte codes and the packed key-event record stored in the FIFO.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 receiver: glitch filter on ps2c, falling-edge tick, 11-bit frame FSM
// with inter-edge timeout. Emits a one-cycle good-byte strobe or frame_err.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [FILTER_LEN-1:0] filt;
  logic                  f_clk;
  logic                  f_next;
  logic                  tick;
  ps2_state_e            state;
  logic [7:0]            sh;
  logic [2:0]            bit_cnt;
  logic                  par;
  logic [TW-1:0]         to_cnt;

  // Filtered clock only changes once the whole window agrees.
  always_comb begin
    f_next = f_clk;
    if (&filt)       f_next = 1'b1;
    else if (~|filt) f_next = 1'b0;
  end

  assign tick = f_clk & ~f_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt       <= '1;
      f_clk      <= 1'b1;
      state      <= ST_IDLE;
      sh         <= '0;
      bit_cnt    <= '0;
      par        <= 1'b0;
      to_cnt     <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
      frame_err  <= 1'b0;
    end else begin
      filt       <= {filt[FILTER_LEN-2:0], ps2c};
      f_clk      <= f_next;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;

      // A stalled frame is abandoned; the case below only acts on ticks.
      if (state != ST_IDLE && !tick) begin
        if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
          state     <= ST_IDLE;
          frame_err <= 1'b1;
          to_cnt    <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end else begin
        to_cnt <= '0;
      end

      if (tick) begin
        case (state)
          ST_IDLE: begin
            if (ps2d) begin
              frame_err <= 1'b1;
            end else if (rx_en) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            sh      <= {ps2d, sh[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par   <= ps2d;
            state <= ST_STOP;
          end
          ST_STOP: begin
            if ((^{sh, par}) && ps2d) begin
              byte_valid <= 1'b1;
              rx_byte    <= sh;
            end else begin
              frame_err <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_queue.sv
// PS/2 key-event queue: decodes E0/F0 prefixes from received bytes and
// stores {ext, brk, code} events in a first-word fall-through FIFO.
module ps2_key_queue
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int REPORT_MAKE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  input  logic       rd_en,
  input  logic       clr_ovf,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic       fifo_full,
  output logic       overflow,
  output logic       frame_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          byte_valid;
  logic [7:0]    rx_byte;
  logic          ext_pend;
  logic          brk_pend;
  key_event_t    mem [FIFO_DEPTH];
  key_event_t    head;
  key_event_t    push_ev;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] new_rd;
  logic [CW-1:0] count;
  logic [CW-1:0] new_count;
  logic          is_prefix;
  logic          push;
  logic          pop;
  logic          push_ok;
  logic          drop;

  ps2_frame_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .rx_en     (rx_en),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  always_comb begin
    is_prefix = (rx_byte == PS2_EXT) || (rx_byte == PS2_BRK);
    push      = byte_valid && !is_prefix && ((REPORT_MAKE != 0) || brk_pend);
    pop       = rd_en && (count != '0);
    push_ok   = push && ((count != CW'(FIFO_DEPTH)) || pop);
    drop      = push && (count == CW'(FIFO_DEPTH)) && !pop;
    new_rd    = pop ? rd_ptr + PW'(1) : rd_ptr;
    new_count = count + CW'(push_ok) - CW'(pop);
    push_ev   = '{ext: ext_pend, brk: brk_pend, code: rx_byte};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (frame_err) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (byte_valid) begin
      if (rx_byte == PS2_EXT) begin
        ext_pend <= 1'b1;
      end else if (rx_byte == PS2_BRK) begin
        brk_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      head     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_ev;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      rd_ptr <= new_rd;
      count  <= new_count;
      // The new head is the entry being written only when it lands in an empty slot pair.
      if (new_count != '0) begin
        if (push_ok && (wr_ptr == new_rd)) head <= push_ev;
        else                               head <= mem[new_rd];
      end
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign key_code  = head.code;
  assign key_ext   = head.ext;
  assign key_break = head.brk;
  assign key_valid = (count != '0);
  assign fifo_full = (count == CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_ps2_key_queue.sv
// Directed bench for ps2_key_queue: bit-level PS/2 frame driver, latency,
// prefix decoding, error/timeout, FIFO overflow and break-only mode.
module tb_ps2_key_queue;

  localparam int TO_CYC = 2000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       rx_en = 1'b1;
  logic       rd_en = 1'b0;
  logic       rd_en2 = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] key_code, key_code2;
  logic       key_ext, key_ext2, key_break, key_break2;
  logic       key_valid, key_valid2, fifo_full, fifo_full2;
  logic       overflow, overflow2, frame_err, frame_err2;

  int errors = 0;
  int checks = 0;
  int err_cnt = 0;
  int err_base;
  logic valid_before, valid_after;
  logic [7:0] exp_q[$];
  logic [7:0] exp_code;

  ps2_key_queue #(.FIFO_DEPTH(4), .TIMEOUT_CYC(TO_CYC), .REPORT_MAKE(1)) dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
    .rd_en(rd_en), .clr_ovf(clr_ovf), .key_code(key_code), .key_ext(key_ext),
    .key_break(key_break), .key_valid(key_valid), .fifo_full(fifo_full),
    .overflow(overflow), .frame_err(frame_err)
  );

  ps2_key_queue #(.FIFO_DEPTH(4), .TIMEOUT_CYC(TO_CYC), .REPORT_MAKE(0)) dut2 (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
    .rd_en(rd_en2), .clr_ovf(clr_ovf), .key_code(key_code2), .key_ext(key_ext2),
    .key_break(key_break2), .key_valid(key_valid2), .fifo_full(fifo_full2),
    .overflow(overflow2), .frame_err(frame_err2)
  );

  // Clock and frame_err pulse counter
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

  // Driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rd_en = 1'b0; rd_en2 = 1'b0; clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2d = b;
    repeat (10) @(negedge clk);
    ps2c = 1'b0;
    repeat (20) @(negedge clk);
    ps2c = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Stop bit is driven by hand so key_valid can be sampled at T+1 and T+2.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic pop_on_push);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ bad_par);
    @(negedge clk);
    ps2d = 1'b1;
    repeat (10) @(negedge clk);
    ps2c = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    valid_before = key_valid;
    if (pop_on_push) rd_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rd_en = 1'b0;
    valid_after = key_valid;
    repeat (10) @(negedge clk);
    ps2c = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    checks++; if ({key_ext, key_break, key_code} !== 10'h000) begin errors++; $display("FAIL reset_head got=%h exp=000", {key_ext, key_break, key_code}); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL reset_err got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_single();
    send_frame(8'h1C, 1'b0, 1'b0);
    checks++; if (valid_before !== 1'b0) begin errors++; $display("FAIL lat_t1 got=%b exp=0", valid_before); end
    checks++; if (valid_after !== 1'b1) begin errors++; $display("FAIL lat_t2 got=%b exp=1", valid_after); end
    checks++; if ({key_ext, key_break, key_code} !== 10'h01C) begin errors++; $display("FAIL single_head got=%h exp=01C", {key_ext, key_break, key_code}); end
    pop();
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL single_empty got=%b exp=0", key_valid); end
    checks++; if (key_code !== 8'h1C) begin errors++; $display("FAIL single_hold got=%h exp=1C", key_code); end
    pop();
    checks++; if (key_valid !== 1'b0 || key_code !== 8'h1C) begin errors++; $display("FAIL empty_pop got=%b/%h exp=0/1C", key_valid, key_code); end
  endtask

  task automatic test_ext_break();
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL prefix_queued got=%b exp=0", key_valid); end
    send_frame(8'h75, 1'b0, 1'b0);
    checks++; if ({key_valid, key_ext, key_break, key_code} !== 11'h775) begin errors++; $display("FAIL extbrk_head got=%h exp=775", {key_valid, key_ext, key_break, key_code}); end
    pop();
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL extbrk_count got=%b exp=0", key_valid); end
  endtask

  task automatic test_bad_parity();
    send_frame(8'hE0, 1'b0, 1'b0);
    err_base = err_cnt;
    send_frame(8'h2B, 1'b1, 1'b0);
    checks++; if (err_cnt - err_base !== 1) begin errors++; $display("FAIL parity_err got=%0d exp=1", err_cnt - err_base); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL parity_empty got=%b exp=0", key_valid); end
    send_frame(8'h1C, 1'b0, 1'b0);
    checks++; if ({key_ext, key_break, key_code} !== 10'h01C) begin errors++; $display("FAIL err_clears_pend got=%h exp=01C", {key_ext, key_break, key_code}); end
    pop();
    err_base = err_cnt;
    send_bit(1'b1);
    checks++; if (err_cnt - err_base !== 1) begin errors++; $display("FAIL idle_start_err got=%0d exp=1", err_cnt - err_base); end
  endtask

  task automatic test_timeout();
    err_base = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (TO_CYC + 100) @(negedge clk);
    checks++; if (err_cnt - err_base !== 1) begin errors++; $display("FAIL timeout_err got=%0d exp=1", err_cnt - err_base); end
    send_frame(8'h33, 1'b0, 1'b0);
    checks++; if ({key_valid, key_ext, key_break, key_code} !== 11'h433) begin errors++; $display("FAIL timeout_next got=%h exp=433", {key_valid, key_ext, key_break, key_code}); end
    pop();
  endtask

  task automatic test_reset_mid_frame();
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    do_reset();
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL midreset_empty got=%b exp=0", key_valid); end
    send_frame(8'h1C, 1'b0, 1'b0);
    checks++; if ({key_valid, key_code} !== 9'h11C) begin errors++; $display("FAIL midreset_next got=%h exp=11C", {key_valid, key_code}); end
    pop();
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5];
    codes = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_frame(codes[i], 1'b0, 1'b0);
      if (i < 4) exp_q.push_back(codes[i]);
    end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", fifo_full); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    while (exp_q.size() > 0) begin
      exp_code = exp_q.pop_front();
      checks++; if (key_valid !== 1'b1 || key_code !== exp_code) begin errors++; $display("FAIL ovf_order got=%b/%h exp=1/%h", key_valid, key_code, exp_code); end
      pop();
    end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got=%b exp=0", key_valid); end
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h41 + 8'(i), 1'b0, 1'b0);
      exp_q.push_back(8'h41 + 8'(i));
    end
    send_frame(8'h45, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h45);
    checks++; if (overflow !== 1'b0 || fifo_full !== 1'b1) begin errors++; $display("FAIL full_pushpop got=%b/%b exp=0/1", overflow, fifo_full); end
    while (exp_q.size() > 0) begin
      exp_code = exp_q.pop_front();
      checks++; if (key_valid !== 1'b1 || key_code !== exp_code) begin errors++; $display("FAIL full_pushpop_order got=%b/%h exp=1/%h", key_valid, key_code, exp_code); end
      pop();
    end
  endtask

  task automatic test_report_make();
    do_reset();
    send_frame(8'h2C, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h2C, 1'b0, 1'b0);
    checks++; if ({key_valid2, key_ext2, key_break2, key_code2} !== 11'h52C) begin errors++; $display("FAIL brkonly_head got=%h exp=52C", {key_valid2, key_ext2, key_break2, key_code2}); end
    @(negedge clk); rd_en2 = 1'b1;
    @(negedge clk); rd_en2 = 1'b0;
    checks++; if (key_valid2 !== 1'b0) begin errors++; $display("FAIL brkonly_count got=%b exp=0", key_valid2); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ext_break();
    test_bad_parity();
    test_timeout();
    test_reset_mid_frame();
    test_overflow();
    test_back_to_back();
    test_report_make();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
